// File: rtl/piso_tx_if.sv
// Handshake and serial-line bundle for the parallel-in/serial-out transmitter.
interface piso_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             dout;
    logic             dout_valid;
    logic             first;
    logic             last;
    logic             busy;

    modport master (
        output din, load,
        input  ready, dout, dout_valid, first, last, busy
    );

    modport slave (
        input  din, load,
        output ready, dout, dout_valid, first, last, busy
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: load/ready word intake, one bit per clock,
// first/last frame markers, gap-free back-to-back frames.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    piso_tx_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             shifting;
    logic             at_last;
    logic             ready;
    logic             accept;

    assign shifting = (state == SHIFT);
    assign at_last  = shifting && (cnt == CNT_LAST);
    // ready depends on registers only, so load never ripples into it
    assign ready    = (state == IDLE) || at_last;
    assign accept   = bus.load && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    sreg_n  = bus.din;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (at_last) begin
                    if (accept) begin
                        sreg_n = bus.din;
                        cnt_n  = '0;
                    end else begin
                        sreg_n  = '0;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end else begin
                    sreg_n = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
                    cnt_n  = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.ready      = ready;
    assign bus.dout       = shifting && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
    assign bus.dout_valid = shifting;
    assign bus.busy       = shifting;
    assign bus.first      = shifting && (cnt == '0);
    assign bus.last       = at_last;
endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances checked every cycle against
// a frame-queue model, plus directed frames with literal expectations and loopback.
module tb_piso_tx;
    localparam int W = 8;

    logic clk;
    logic rst_n;

    piso_tx_if #(.WIDTH(W)) ifm ();
    piso_tx_if #(.WIDTH(W)) ifl ();

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(ifm));
    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(ifl));

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // Model: each accepted word becomes WIDTH queued symbols {dout, first, last};
    // one symbol is consumed per clock. The block can accept while at most the
    // final symbol of the current frame is still showing.
    typedef struct packed {
        logic d;
        logic f;
        logic l;
    } sym_t;

    sym_t qm[$];
    sym_t ql[$];

    function automatic void push_frame(inout sym_t q[$], input logic [W-1:0] w, input bit msb);
        for (int k = 0; k < W; k++) begin
            sym_t s;
            s.d = msb ? w[W-1-k] : w[k];
            s.f = (k == 0);
            s.l = (k == W - 1);
            q.push_back(s);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qm.delete();
            ql.delete();
        end else begin
            bit am, al;
            am = ifm.load && (qm.size() <= 1);
            al = ifl.load && (ql.size() <= 1);
            if (qm.size() > 0) void'(qm.pop_front());
            if (ql.size() > 0) void'(ql.pop_front());
            if (am) push_frame(qm, ifm.din, 1'b1);
            if (al) push_frame(ql, ifl.din, 1'b0);
        end
    end

    // {dout, dout_valid, first, last, busy, ready}
    function automatic logic [5:0] expect_of(input sym_t q[$]);
        if (q.size() == 0) return 6'b000001;
        return {q[0].d, 1'b1, q[0].f, q[0].l, 1'b1, (q.size() == 1)};
    endfunction

    function automatic logic [5:0] outs(input bit sel);
        if (sel)
            return {ifl.dout, ifl.dout_valid, ifl.first, ifl.last, ifl.busy, ifl.ready};
        return {ifm.dout, ifm.dout_valid, ifm.first, ifm.last, ifm.busy, ifm.ready};
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_msb", 32'(outs(1'b0)), 32'(expect_of(qm)));
            chk("model_lsb", 32'(outs(1'b1)), 32'(expect_of(ql)));
        end
    end

    // Capture register fed directly by the MSB-first line.
    logic [W-1:0] cap;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cap <= '0;
        else if (ifm.dout_valid) cap <= {cap[W-2:0], ifm.dout};
    end

    task automatic drive(input bit sel, input logic ld, input logic [W-1:0] d);
        if (sel) begin
            ifl.load = ld;
            ifl.din  = d;
        end else begin
            ifm.load = ld;
            ifm.din  = d;
        end
    endtask

    // Leaves time at accept edge + 2, i.e. inside the cycle showing frame bit 0.
    task automatic start(input bit sel, input logic [W-1:0] word);
        int n;
        @(posedge clk); #2;
        drive(sel, 1'b1, word);
        n = 0;
        while (!outs(sel)[0] && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 100) chk("ready_timeout", 32'(n), 32'd0);
        @(posedge clk); #2;
        drive(sel, 1'b0, '0);
    endtask

    task automatic collect8(input bit sel, output logic [7:0] d, output logic [7:0] v,
                            output logic [7:0] f, output logic [7:0] l, output logic [7:0] r);
        logic [5:0] o;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            o = outs(sel);
            d[7-i] = o[5];
            v[7-i] = o[4];
            f[7-i] = o[3];
            l[7-i] = o[2];
            r[7-i] = o[0];
        end
    endtask

    initial begin
        logic [7:0]  d, v, f, l, r;
        logic [15:0] d16, f16, l16, v16;
        logic [5:0]  o;
        logic [7:0]  words [4];
        int          widx, cidx;
        bit          pend, acc;

        rst_n = 1'b0;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        #1;
        chk("reset_outs_msb", 32'(outs(1'b0)), 32'h01);
        chk("reset_outs_lsb", 32'(outs(1'b1)), 32'h01);
        #16 rst_n = 1'b1;
        cmp_en = 1'b1;

        // Single word, MSB first
        start(0, 8'hA5);
        collect8(0, d, v, f, l, r);
        chk("a5_dout", 32'(d), 32'hA5);
        chk("a5_valid", 32'(v), 32'hFF);
        chk("a5_first", 32'(f), 32'h80);
        chk("a5_last", 32'(l), 32'h01);
        chk("a5_ready", 32'(r), 32'h01);
        @(negedge clk);
        chk("a5_idle", 32'(outs(1'b0)), 32'h01);

        // Back-to-back with load held
        @(posedge clk); #2;
        drive(0, 1'b1, 8'hA5);
        @(posedge clk); #2;
        drive(0, 1'b1, 8'h3C);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            o = outs(1'b0);
            d16[15-i] = o[5];
            v16[15-i] = o[4];
            f16[15-i] = o[3];
            l16[15-i] = o[2];
            if (i == 7) begin
                @(posedge clk); #2;
                drive(0, 1'b0, '0);
            end
        end
        chk("b2b_dout", 32'(d16), 32'hA53C);
        chk("b2b_valid", 32'(v16), 32'hFFFF);
        chk("b2b_first", 32'(f16), 32'h8080);
        chk("b2b_last", 32'(l16), 32'h0101);

        // Load while busy is ignored
        start(0, 8'hF0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            d[7-i] = ifm.dout;
            if (i == 1) begin
                @(posedge clk); #2;
                drive(0, 1'b1, 8'hFF);
            end else if (i == 2) begin
                @(posedge clk); #2;
                drive(0, 1'b0, '0);
            end
        end
        chk("busy_load_dout", 32'(d), 32'hF0);
        repeat (3) @(negedge clk);
        chk("busy_load_no_frame", 32'(ifm.dout_valid), 32'd0);

        // LSB first
        start(1, 8'h01);
        collect8(1, d, v, f, l, r);
        chk("lsb_dout", 32'(d), 32'h80);
        chk("lsb_first", 32'(f), 32'h80);
        chk("lsb_last", 32'(l), 32'h01);

        // Async reset in the middle of a frame
        start(0, 8'hFF);
        repeat (4) @(negedge clk);
        chk("pre_reset_valid", 32'(ifm.dout_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outs", 32'(outs(1'b0)), 32'h01);
        @(negedge clk);
        #2 rst_n = 1'b1;
        start(0, 8'h81);
        collect8(0, d, v, f, l, r);
        chk("post_reset_dout", 32'(d), 32'h81);
        chk("post_reset_first", 32'(f), 32'h80);
        chk("post_reset_last", 32'(l), 32'h01);

        // Loopback into the capture register
        words[0] = 8'h5A; words[1] = 8'hC3; words[2] = 8'h00; words[3] = 8'hFF;
        widx = 0; cidx = 0; pend = 0;
        @(posedge clk); #2;
        drive(0, 1'b1, words[0]);
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            if (pend) begin
                if (cidx < 4) chk("loopback_word", 32'(cap), 32'(words[cidx]));
                cidx++;
            end
            pend = ifm.last;
            acc  = ifm.ready && ifm.load;
            @(posedge clk); #2;
            if (acc) begin
                widx++;
                if (widx < 4) drive(0, 1'b1, words[widx]);
                else drive(0, 1'b0, '0);
            end
        end
        chk("loopback_count", 32'(cidx), 32'd4);

        // Randomized traffic on both instances, with occasional mid-cycle resets
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            drive(0, ($urandom_range(0, 3) == 0), W'($urandom));
            drive(1, ($urandom_range(0, 2) == 0), W'($urandom));
            if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
